// File: rtl/spike_event_ctrl.sv
// Spike event sequencer: walks one timestep's spike vector lowest index first and
// strobes accumulate/activate to all units. Optional watchdog: SPK_CTRL_WATCHDOG_EN.
module spike_event_ctrl #(
    parameter int unsigned NUM_INPUTS     = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned NUM_UNITS      = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_INPUTS-1:0] spk_in,
    input  logic [NUM_UNITS-1:0]  unit_done,
    output logic                  layer_acc,
    output logic                  layer_act,
    output logic [ADDR_W-1:0]     base_spk_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       spk_count,
    output logic                  err
);

    typedef enum logic [2:0] {IDLE, SCAN, WAIT_ACC, ACT, WAIT_ACT, FIN} state_t;

    state_t                state, state_d;
    logic [NUM_INPUTS-1:0] spk_reg, spk_reg_d;
    logic [NUM_UNITS-1:0]  done_mask, done_mask_d, mask_upd;
    logic [ADDR_W-1:0]     addr_d, idx;
    logic                  idx_vld;
    logic [ADDR_W:0]       cnt_d;
    logic                  acc_d, act_d, done_d;
    logic                  wd_hit;

    always_comb begin
        idx     = '0;
        idx_vld = 1'b0;
        for (int unsigned i = NUM_INPUTS; i > 0; i--) begin
            if (spk_reg[i-1]) begin
                idx     = ADDR_W'(i - 1);
                idx_vld = 1'b1;
            end
        end
    end

    // The strobe is high only in the first cycle of a wait phase; replies then are stale.
    always_comb begin
        mask_upd = done_mask | ((layer_acc || layer_act) ? '0 : unit_done);
    end

`ifdef SPK_CTRL_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == WAIT_ACC || state == WAIT_ACT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
                if (wd_hit && !(&mask_upd))
                    err <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        spk_reg_d   = spk_reg;
        done_mask_d = done_mask;
        addr_d      = base_spk_addr;
        cnt_d       = spk_count;
        acc_d       = 1'b0;
        act_d       = 1'b0;
        done_d      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    spk_reg_d = spk_in;
                    cnt_d     = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (idx_vld) begin
                    addr_d         = idx;
                    spk_reg_d[idx] = 1'b0;
                    cnt_d          = spk_count + (ADDR_W+1)'(1);
                    acc_d          = 1'b1;
                    done_mask_d    = '0;
                    state_d        = WAIT_ACC;
                end else begin
                    state_d = ACT;
                end
            end
            WAIT_ACC: begin
                done_mask_d = mask_upd;
                if (&mask_upd || wd_hit)
                    state_d = SCAN;
            end
            ACT: begin
                act_d       = 1'b1;
                done_mask_d = '0;
                state_d     = WAIT_ACT;
            end
            WAIT_ACT: begin
                done_mask_d = mask_upd;
                if (&mask_upd || wd_hit)
                    state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            spk_reg       <= '0;
            done_mask     <= '0;
            base_spk_addr <= '0;
            spk_count     <= '0;
            layer_acc     <= 1'b0;
            layer_act     <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            spk_reg       <= spk_reg_d;
            done_mask     <= done_mask_d;
            base_spk_addr <= addr_d;
            spk_count     <= cnt_d;
            layer_acc     <= acc_d;
            layer_act     <= act_d;
            done          <= done_d;
            busy          <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_spike_event_ctrl.sv
// Bench for spike_event_ctrl: vector table, hand sequences and randomized runs
// checked against a timing/ordering model of the sequencer.
module tb_spike_event_ctrl;

    localparam int NI = 32;
    localparam int AW = 5;
    localparam int NU = 5;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [NI-1:0] spk_in = '0;
    logic [NU-1:0] unit_done = '0;
    logic          layer_acc, layer_act, busy, done, err;
    logic [AW-1:0] base_spk_addr;
    logic [AW:0]   spk_count;

    int n_chk = 0;
    int n_err = 0;
    int unit_dly [NU];
    bit dup = 1'b0;

    spike_event_ctrl #(
        .NUM_INPUTS(NI), .ADDR_W(AW), .NUM_UNITS(NU), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .spk_in(spk_in), .unit_done(unit_done),
        .layer_acc(layer_acc), .layer_act(layer_act), .base_spk_addr(base_spk_addr),
        .busy(busy), .done(done), .spk_count(spk_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Units reply unit_dly cycles after seeing a strobe (0 = never); dup adds a repeat pulse.
    initial begin
        int cd [NU];
        bit rep [NU];
        logic [NU-1:0] nd;
        for (int u = 0; u < NU; u++) begin cd[u] = 0; rep[u] = 1'b0; end
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                for (int u = 0; u < NU; u++) begin cd[u] = 0; rep[u] = 1'b0; end
                unit_done = '0;
            end else begin
                nd = '0;
                for (int u = 0; u < NU; u++) begin
                    if (rep[u]) begin nd[u] = 1'b1; rep[u] = 1'b0; end
                    if (cd[u] > 0) begin
                        cd[u]--;
                        if (cd[u] == 0) begin nd[u] = 1'b1; rep[u] = dup; end
                    end
                    if ((layer_acc || layer_act) && unit_dly[u] > 0) cd[u] = unit_dly[u];
                end
                unit_done = nd;
            end
        end
    end

    task automatic set_dly(input int d);
        for (int u = 0; u < NU; u++) unit_dly[u] = d;
    endtask

    // One timestep; expectations from spike list, slowest unit and per-phase cost.
    task automatic run(input logic [NI-1:0] vec, input bit inject,
                       output int lat, output int cnt, output int last_addr);
        int exp_addr[$];
        int got_addr[$];
        int got_cyc[$];
        int d_max, exp_lat, acts, cur, n;
        bit stable, bsy_ok;
        d_max = 0;
        for (int u = 0; u < NU; u++) if (unit_dly[u] > d_max) d_max = unit_dly[u];
        for (int i = 0; i < NI; i++) if (vec[i]) exp_addr.push_back(i);
        exp_lat = exp_addr.size() * (d_max + 2) + d_max + 4;
        start = 1'b1; spk_in = vec;
        @(posedge clk); #1;
        start = 1'b0; spk_in = $urandom;
        lat = -1; cnt = -1; acts = 0; cur = -1; stable = 1'b1; bsy_ok = 1'b1;
        for (int c = 1; c <= 400 && lat < 0; c++) begin
            if (busy !== 1'b1) bsy_ok = 1'b0;
            @(posedge clk); #1;
            if (inject && c == 3) begin start = 1'b1; spk_in = ~vec; end
            else start = 1'b0;
            if (layer_acc) begin
                got_addr.push_back(int'(base_spk_addr));
                got_cyc.push_back(c);
                cur = int'(base_spk_addr);
            end else if (cur >= 0 && int'(base_spk_addr) != cur) stable = 1'b0;
            if (layer_act) acts++;
            if (done) begin lat = c; cnt = int'(spk_count); end
        end
        start = 1'b0;
        chk("latency", lat, exp_lat);
        chk("spk_count", cnt, exp_addr.size());
        chk("acc_pulses", got_addr.size(), exp_addr.size());
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk("acc_addr", got_addr[i], exp_addr[i]);
            chk("acc_cycle", got_cyc[i], 1 + i * (d_max + 2));
        end
        chk("act_pulses", acts, 1);
        chk("addr_stable", stable, 1);
        chk("busy_during_walk", bsy_ok, 1);
        chk("busy_after_done", busy, 0);
        chk("err_clear", err, 0);
        last_addr = (got_addr.size() > 0) ? got_addr[got_addr.size()-1] : -1;
    endtask

    typedef struct {
        logic [NI-1:0] vec;
        int            dly;
        int            exp_cnt;
        int            exp_lat;
        int            exp_last;
    } vec_t;

    initial begin
        vec_t tbl [5];
        int lat, cnt, last;
        bit quiet;

        tbl[0] = '{32'h0000_0000, 1, 0,   5, -1};
        tbl[1] = '{32'h0000_0105, 2, 3,  18,  8};
        tbl[2] = '{32'h8000_0000, 1, 1,   8, 31};
        tbl[3] = '{32'hFFFF_FFFF, 1, 32, 101, 31};
        tbl[4] = '{32'h0000_0001, 3, 1,  12,  0};

        set_dly(1);
        #1;
        chk("rst_layer_acc", layer_acc, 0);
        chk("rst_layer_act", layer_act, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spk_count", spk_count, 0);
        chk("rst_base_addr", base_spk_addr, 0);
        chk("rst_err", err, 0);
        #12 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            set_dly(tbl[i].dly);
            run(tbl[i].vec, 1'b0, lat, cnt, last);
            chk("tbl_latency", lat, tbl[i].exp_lat);
            chk("tbl_count", cnt, tbl[i].exp_cnt);
            chk("tbl_last_addr", last, tbl[i].exp_last);
            repeat (2) @(posedge clk);
            #1;
        end

        // Staggered replies: unit0 first, units 3 and 4 together last.
        unit_dly[0] = 1; unit_dly[1] = 2; unit_dly[2] = 3; unit_dly[3] = 4; unit_dly[4] = 4;
        run(32'h0000_0050, 1'b0, lat, cnt, last);
        chk("stagger_latency", lat, 20);
        chk("stagger_last", last, 6);

        // A second start while busy must be ignored.
        set_dly(2);
        run(32'h0000_0105, 1'b1, lat, cnt, last);
        chk("inject_latency", lat, 18);
        chk("inject_count", cnt, 3);
        chk("inject_last", last, 8);

        // Asynchronous reset in the middle of WAIT_ACC.
        set_dly(2);
        start = 1'b1; spk_in = '1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        chk("busy_pre_reset", busy, 1);
        rst = 1'b0; #1;
        chk("mid_rst_acc", layer_acc, 0);
        chk("mid_rst_act", layer_act, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_count", spk_count, 0);
        chk("mid_rst_addr", base_spk_addr, 0);
        chk("mid_rst_err", err, 0);
        @(posedge clk); #3 rst = 1'b1;
        quiet = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (layer_acc || layer_act || busy || done) quiet = 1'b0;
        end
        chk("post_rst_quiet", quiet, 1);
        run(32'hFFFF_FFFF, 1'b0, lat, cnt, last);
        chk("post_rst_count", cnt, 32);
        chk("post_rst_latency", lat, 134);

        // Randomized timesteps.
        for (int r = 0; r < 20; r++) begin
            logic [NI-1:0] v;
            for (int u = 0; u < NU; u++) unit_dly[u] = $urandom_range(1, 4);
            dup = 1'($urandom_range(0, 1));
            v = $urandom;
            if ($urandom_range(0, 1) == 1) v = v & $urandom & $urandom;
            if ($urandom_range(0, 7) == 0) v = '0;
            run(v, 1'($urandom_range(0, 1)), lat, cnt, last);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        dup = 1'b0;

        // Unit 3 never answers.
        set_dly(1);
        unit_dly[3] = 0;
        start = 1'b1; spk_in = 32'h0000_0003;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef SPK_CTRL_WATCHDOG_EN
        begin
            int done_cyc, acc_n;
            bit err_ok;
            done_cyc = -1; acc_n = 0; err_ok = 1'b1;
            for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
                @(posedge clk); #1;
                if (c == 8) chk("wd_err_before", err, 0);
                if (c == 9) chk("wd_err_rise", err, 1);
                if (c > 9 && err !== 1'b1) err_ok = 1'b0;
                if (layer_acc) acc_n++;
                if (done) begin done_cyc = c; chk("wd_count", spk_count, 2); end
            end
            chk("wd_done_cycle", done_cyc, 2 * (TO + 1) + TO + 3);
            chk("wd_acc_pulses", acc_n, 2);
            chk("wd_err_held", err_ok, 1);
            repeat (5) @(posedge clk);
            #1;
            chk("wd_err_sticky", err, 1);
        end
`else
        begin
            int acc_n;
            bit held;
            acc_n = 0; held = 1'b1;
            for (int c = 1; c <= 60; c++) begin
                @(posedge clk); #1;
                if (layer_acc) acc_n++;
                if (busy !== 1'b1 || done !== 1'b0 || layer_act !== 1'b0) held = 1'b0;
            end
            chk("stuck_acc_pulses", acc_n, 1);
            chk("stuck_busy_held", held, 1);
            chk("stuck_err", err, 0);
        end
`endif
        #2 rst = 1'b0; #1;
        chk("final_rst_err", err, 0);
        chk("final_rst_busy", busy, 0);
        @(posedge clk); #3 rst = 1'b1;
        set_dly(1);
        run(32'h0000_0400, 1'b0, lat, cnt, last);
        chk("recover_last", last, 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached with %0d checks", n_chk);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/spike_event_ctrl.md
Name: spike_event_ctrl

Overview:
- Upstream sequencer for a layer's neural units.
- Latches one timestep's input spike vector and walks the set bits lowest-index first.
- For each spike: presents the presynaptic index on base_spk_addr, pulses layer_acc to all units, and waits for every unit to report done.
- After the last spike: pulses layer_act once, waits for all units, then signals layer completion.

Parameters:
- NUM_INPUTS, 32, width of input spike vector (presynaptic neurons).
- ADDR_W, 5, width of base_spk_addr; must satisfy 2**ADDR_W >= NUM_INPUTS.
- NUM_UNITS, 5, number of neural units driven and monitored.
- TIMEOUT_CYCLES, 255, watchdog limit per wait phase (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to process spk_in; sampled only in IDLE.
- spk_in  in  NUM_INPUTS  spike vector for the current timestep.
- unit_done  in  NUM_UNITS  per-unit completion pulses, one cycle each.
- layer_acc  out  1  one-cycle accumulate strobe to all units.
- layer_act  out  1  one-cycle activation strobe to all units.
- base_spk_addr  out  ADDR_W  index of the spike being processed; held stable from the layer_acc cycle until its wait phase ends.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the layer finishes.
- spk_count  out  ADDR_W+1  number of spikes processed this timestep; valid while done is high, held until the next start.
- err  out  1  sticky watchdog flag; tied 0 without the optional feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - spk_reg, done_mask, base_spk_addr, spk_count, layer_acc, layer_act, done and err all clear to 0.
  - Reset mid-operation abandons the walk; no further strobes are issued.
- All outputs are registered.
- States: IDLE, SCAN, WAIT_ACC, ACT, WAIT_ACT, FIN.
- IDLE:
  - On start=1: spk_reg<=spk_in, spk_count<=0, go to SCAN.
  - start in any other state is ignored.
- SCAN:
  - A combinational priority encoder finds the lowest set bit of spk_reg.
  - If one is found:
    - base_spk_addr<=idx;
    - clear spk_reg[idx];
    - spk_count<=spk_count+1;
    - layer_acc<=1 for one cycle;
    - done_mask<=0;
    - go to WAIT_ACC.
  - If spk_reg==0: go to ACT. An all-zero vector goes straight to ACT, because leak and bias must still be applied.
- WAIT_ACC:
  - done_mask |= unit_done every cycle.
  - unit_done pulses arriving in the same cycle as the layer_acc pulse are ignored; units respond at least one cycle later.
  - When done_mask (including this cycle's pulses) is all ones, go to SCAN. Exit latency is 1 cycle after the last done.
- ACT: layer_act<=1 for one cycle, done_mask<=0, go to WAIT_ACT.
- WAIT_ACT: same mask rule as WAIT_ACC; when complete, go to FIN.
- FIN: done=1 for one cycle, go to IDLE.
- Per-spike cost: 1 SCAN cycle plus the wait cycles.
- Minimum layer latency from start to done, with zero spikes and units answering in 1 cycle: 5 cycles.
- Duplicate unit_done pulses from a unit within one phase are harmless (OR mask).
- spk_count saturation is unnecessary: the maximum is NUM_INPUTS, which fits in ADDR_W+1 bits.

Optional Feature:
- Macro: SPK_CTRL_WATCHDOG_EN.
- Defined:
  - A cycle counter resets on entry to WAIT_ACC or WAIT_ACT.
  - If it reaches TIMEOUT_CYCLES before done_mask is complete, err<=1 (sticky until reset) and the FSM proceeds as if all units had completed.
- Not defined:
  - No counter is built.
  - Wait states block indefinitely.
  - err is constant 0.

Test Plan:
- Reset then start with spk_in=0 and units answering 1 cycle after each strobe:
  - no layer_acc;
  - exactly one layer_act;
  - done 5 cycles after start;
  - spk_count=0.
- spk_in=32'h0000_0105, units answering after 2 cycles:
  - layer_acc pulses with base_spk_addr sequence 0, 2, 8;
  - then one layer_act;
  - done with spk_count=3.
- NUM_UNITS=5 with unit_done bits arriving staggered over 4 cycles (bit0 first, bits 3–4 last together):
  - SCAN is re-entered only on the cycle after bits 3–4;
  - base_spk_addr holds stable throughout WAIT_ACC.
- start asserted again while busy with a different spk_in:
  - ignored;
  - the original walk completes with the original vector.
- rst driven low asynchronously mid-WAIT_ACC (between clock edges) with spk_in=32'hFFFF_FFFF:
  - all outputs read 0 immediately;
  - after release, a new start processes all 32 spikes;
  - done with spk_count=32.
- Watchdog build with TIMEOUT_CYCLES=8 and unit 3 never answering:
  - err rises 8 cycles into the first WAIT_ACC;
  - the walk continues to done;
  - err stays 1 until reset.
  - Non-watchdog build with the same stimulus: the FSM stays in WAIT_ACC and busy stays 1.
